micro_cpu: RTL and testbench
============================

MICRO_CPU -- requirements
Module: micro_cpu

Interface
REQ-001 Parameter DATA_W, 32, datapath and register width.
REQ-002 Parameter NREG, 8, register count (power of 2, >=4); RSEL_W=log2(NREG).
REQ-003 Parameter ADDR_W, 4, data RAM address width (depth 2^ADDR_W words).
REQ-004 Parameter MPC_W, 8, microprogram counter width (control store depth 2^MPC_W).
REQ-005 Microword width UW=MPC_W+RSEL_W+NREG+11; fields MSB->LSB: NEXT[MPC_W], JAMN, JAMZ, SHIFT[2], ALU[4], CWR[NREG], MEMWR, MEMRD, BSEL[RSEL_W], HALT.
REQ-006 clock  in  1  single clock; all state updates on rising edge.
REQ-007 reset  in  1  synchronous, active-high.
REQ-008 start  in  1  begin/restart execution at microaddress 0.
REQ-009 cs_we  in  1  control store write strobe.
REQ-010 cs_addr  in  MPC_W  control store write address.
REQ-011 cs_data  in  UW  control store write data.
REQ-012 busy  out  1  high in RUN.
REQ-013 halted  out  1  high in HALT.
REQ-014 mpc  out  MPC_W  current microprogram counter.
REQ-015 out_c, out_b, out_ram_read, out_ram_write  out  DATA_W each  registered trace of C bus, B bus, RAM read data, MDR.

Function
REQ-016 FSM states IDLE, RUN, HALT; IDLE->RUN and HALT->RUN on start with mpc=0; RUN->HALT after the cycle executing a microword with HALT=1; start in RUN ignored.
REQ-017 Register map: R0=H (ALU A input), R1=MAR, R2=MDR, R3..R(NREG-1) general.
REQ-018 One microword per RUN cycle, read combinationally from control store at mpc.
REQ-019 B bus = register[BSEL]; ALU ops: 0 H, 1 B, 2 H+B, 3 H-B, 4 B+1, 5 H&B, 6 H|B, 7 ~B, 8 H*B (see REQ-031), others 0; sums truncated to DATA_W.
REQ-020 SHIFT: 00 none, 01 logical left 1, 10 arithmetic right 1, 11 logical left 8; C bus = shifter output.
REQ-021 Every register whose CWR bit is 1 loads the C bus at the clock edge; multiple bits allowed.
REQ-022 N = ALU result MSB, Z = (ALU result==0), both pre-shift, same cycle.
REQ-023 Next mpc = NEXT with MSB ORed with (JAMN&N)|(JAMZ&Z).
REQ-024 MEMWR: RAM[MAR[ADDR_W-1:0]] <= MDR (pre-update value) at the edge.
REQ-025 MEMRD: MDR <= RAM[MAR[ADDR_W-1:0]] at the edge, visible to the next microword; overrides CWR load of MDR in the same cycle; MEMWR+MEMRD same address returns old data.
REQ-026 cs_we writes control store only in IDLE or HALT; ignored in RUN.
REQ-027 Trace outputs update every RUN cycle with that cycle's C bus, B bus, RAM[MAR] and MDR; hold in IDLE/HALT.
REQ-028 In IDLE/HALT no register, RAM or mpc changes.

Reset
REQ-029 reset: state IDLE, mpc 0, all registers 0, all outputs 0; aborts RUN in the same edge; control store and RAM contents not cleared.
REQ-030 reset takes priority over start and cs_we.

Configuration
REQ-031 Macro ALU_MUL_EN: defined -> ALU op 8 = low DATA_W bits of H*B; undefined -> op 8 yields 0 and no multiplier is built.

Verification
REQ-032 Load {H=5 via B+1 chain, R3=7}, ALU=2, CWR=R4 -> R4=12, out_c=12, N=0,Z=0.
REQ-033 MAR=3, MDR=0xDEAD, MEMWR; next word MEMRD into MDR after MDR cleared -> out_ram_write=0xDEAD one cycle later.
REQ-034 H=4,B=4, ALU=3, JAMZ=1, NEXT=0x05 -> mpc=0x85; with H=4,B=3 -> mpc=0x05.
REQ-035 Microword at 2 with HALT=1 -> halted=1 after 3 RUN cycles, mpc frozen; start -> mpc=0, busy=1.
REQ-036 reset asserted mid-RUN -> next edge busy=0, all registers/outputs 0; control store intact on restart.
REQ-037 H=6,B=7, ALU=8 -> C=42 with ALU_MUL_EN, C=0 without.

Source files
------------

// File: rtl/micro_cpu.sv
// -----------------------------------------------------------------------------
// micro_cpu
//   Small horizontally-microcoded datapath. A writable control store holds
//   microwords; while running, one microword is fetched (combinationally) and
//   executed per clock. Each microword selects a B-bus register, an ALU
//   operation against H, a shift of the ALU result onto the C bus, a set of
//   destination registers, optional data-RAM read/write through MAR/MDR, and
//   the next microaddress (with N/Z "jam" into the MSB for branching).
//
//   Register map: R0 = H (ALU A input), R1 = MAR, R2 = MDR, R3.. general.
//
//   Microword fields, MSB -> LSB:
//     NEXT[MPC_W] JAMN JAMZ SHIFT[2] ALU[4] CWR[NREG] MEMWR MEMRD BSEL[RSEL_W] HALT
//
//   Build option:
//     ALU_MUL_EN  defined   -> ALU op 8 returns low DATA_W bits of H*B
//                 undefined -> ALU op 8 returns 0 and no multiplier exists
//
// Ports
//   clock          in   single clock, all state changes on the rising edge
//   reset          in   synchronous, active-high; wins over start and cs_we
//   start          in   begin/restart at microaddress 0 (ignored while running)
//   cs_we          in   control store write strobe (IDLE/HALT only)
//   cs_addr        in   control store write address
//   cs_data        in   control store write data (one microword)
//   busy           out  high while running
//   halted         out  high after a HALT microword has executed
//   mpc            out  current microprogram counter
//   out_c          out  registered trace of the C bus
//   out_b          out  registered trace of the B bus
//   out_ram_read   out  registered trace of RAM[MAR]
//   out_ram_write  out  registered trace of MDR
// -----------------------------------------------------------------------------
module micro_cpu #(
    parameter int DATA_W = 32,
    parameter int NREG   = 8,
    parameter int ADDR_W = 4,
    parameter int MPC_W  = 8,
    localparam int RSEL_W = $clog2(NREG),
    localparam int UW     = MPC_W + RSEL_W + NREG + 11
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              cs_we,
    input  logic [MPC_W-1:0]  cs_addr,
    input  logic [UW-1:0]     cs_data,
    output logic              busy,
    output logic              halted,
    output logic [MPC_W-1:0]  mpc,
    output logic [DATA_W-1:0] out_c,
    output logic [DATA_W-1:0] out_b,
    output logic [DATA_W-1:0] out_ram_read,
    output logic [DATA_W-1:0] out_ram_write
);

    localparam int HALT_B    = 0;
    localparam int BSEL_LSB  = 1;
    localparam int MEMRD_B   = RSEL_W + 1;
    localparam int MEMWR_B   = RSEL_W + 2;
    localparam int CWR_LSB   = RSEL_W + 3;
    localparam int ALU_LSB   = CWR_LSB + NREG;
    localparam int SHIFT_LSB = ALU_LSB + 4;
    localparam int JAMZ_B    = SHIFT_LSB + 2;
    localparam int JAMN_B    = JAMZ_B + 1;
    localparam int NEXT_LSB  = JAMN_B + 1;

    localparam int REG_H   = 0;
    localparam int REG_MAR = 1;
    localparam int REG_MDR = 2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_HALT
    } state_t;

    state_t             state_q, state_d;
    logic [MPC_W-1:0]   mpc_q, mpc_d;

    logic [UW-1:0]      cstore [0:(1<<MPC_W)-1];
    logic [DATA_W-1:0]  ram    [0:(1<<ADDR_W)-1];
    logic [DATA_W-1:0]  regs_q [0:NREG-1];

    logic [DATA_W-1:0]  traceC_q, traceB_q, traceRd_q, traceWr_q;

    logic [UW-1:0]      uword;
    logic [MPC_W-1:0]   uNext;
    logic               uJamN, uJamZ, uMemWr, uMemRd, uHalt;
    logic [1:0]         uShift;
    logic [3:0]         uAlu;
    logic [NREG-1:0]    uCwr;
    logic [RSEL_W-1:0]  uBsel;

    logic [DATA_W-1:0]  hReg, bBus, mdr, ramRd, aluRes, cBus;
    logic [ADDR_W-1:0]  marLow;
    logic               nFlag, zFlag, jam;
    logic [MPC_W-1:0]   nextMpc;
    logic               running;

    // Microword fetch and field decode
    assign uword  = cstore[mpc_q];
    assign uNext  = uword[NEXT_LSB +: MPC_W];
    assign uJamN  = uword[JAMN_B];
    assign uJamZ  = uword[JAMZ_B];
    assign uShift = uword[SHIFT_LSB +: 2];
    assign uAlu   = uword[ALU_LSB +: 4];
    assign uCwr   = uword[CWR_LSB +: NREG];
    assign uMemWr = uword[MEMWR_B];
    assign uMemRd = uword[MEMRD_B];
    assign uBsel  = uword[BSEL_LSB +: RSEL_W];
    assign uHalt  = uword[HALT_B];

    assign running = (state_q == S_RUN);

    assign hReg   = regs_q[REG_H];
    assign bBus   = regs_q[uBsel];
    assign mdr    = regs_q[REG_MDR];
    assign marLow = regs_q[REG_MAR][ADDR_W-1:0];
    assign ramRd  = ram[marLow];

    // ALU: H is always the A operand, the selected register is B
    always_comb begin
        aluRes = '0;
        case (uAlu)
            4'd0: aluRes = hReg;
            4'd1: aluRes = bBus;
            4'd2: aluRes = hReg + bBus;
            4'd3: aluRes = hReg - bBus;
            4'd4: aluRes = bBus + DATA_W'(1);
            4'd5: aluRes = hReg & bBus;
            4'd6: aluRes = hReg | bBus;
            4'd7: aluRes = ~bBus;
`ifdef ALU_MUL_EN
            4'd8: aluRes = hReg * bBus;
`endif
            default: aluRes = '0;
        endcase
    end

    // Shifter drives the C bus; the flags below look at the unshifted result
    always_comb begin
        cBus = aluRes;
        case (uShift)
            2'b01:   cBus = {aluRes[DATA_W-2:0], 1'b0};
            2'b10:   cBus = {aluRes[DATA_W-1], aluRes[DATA_W-1:1]};
            2'b11:   cBus = {aluRes[DATA_W-9:0], 8'h00};
            default: cBus = aluRes;
        endcase
    end

    assign nFlag   = aluRes[DATA_W-1];
    assign zFlag   = (aluRes == '0);
    assign jam     = (uJamN & nFlag) | (uJamZ & zFlag);
    assign nextMpc = {uNext[MPC_W-1] | jam, uNext[MPC_W-2:0]};

    // Sequencer next-state. A HALT microword still performs its register and
    // memory actions, but the mpc is left pointing at it so the stop address
    // stays visible while halted.
    always_comb begin
        state_d = state_q;
        mpc_d   = mpc_q;
        case (state_q)
            S_IDLE, S_HALT: begin
                if (start) begin
                    state_d = S_RUN;
                    mpc_d   = '0;
                end
            end
            S_RUN: begin
                if (uHalt) begin
                    state_d = S_HALT;
                end else begin
                    mpc_d = nextMpc;
                end
            end
            default: begin
                state_d = S_IDLE;
                mpc_d   = '0;
            end
        endcase
    end

    // Sequencer state register
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            mpc_q   <= '0;
        end else begin
            state_q <= state_d;
            mpc_q   <= mpc_d;
        end
    end

    // Register file: every CWR-selected register takes the C bus; a memory
    // read lands in MDR afterwards so it overrides a C-bus load of MDR.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else if (running) begin
            for (int i = 0; i < NREG; i++) begin
                if (uCwr[i]) begin
                    regs_q[i] <= cBus;
                end
            end
            if (uMemRd) begin
                regs_q[REG_MDR] <= ramRd;
            end
        end
    end

    // Data RAM write port; contents survive reset
    always_ff @(posedge clock) begin
        if (!reset && running && uMemWr) begin
            ram[marLow] <= mdr;
        end
    end

    // Control store write port; only loadable while not executing
    always_ff @(posedge clock) begin
        if (!reset && cs_we && (state_q != S_RUN)) begin
            cstore[cs_addr] <= cs_data;
        end
    end

    // Trace registers capture the pre-edge bus values of each executed cycle
    always_ff @(posedge clock) begin
        if (reset) begin
            traceC_q  <= '0;
            traceB_q  <= '0;
            traceRd_q <= '0;
            traceWr_q <= '0;
        end else if (running) begin
            traceC_q  <= cBus;
            traceB_q  <= bBus;
            traceRd_q <= ramRd;
            traceWr_q <= mdr;
        end
    end

    assign busy          = (state_q == S_RUN);
    assign halted        = (state_q == S_HALT);
    assign mpc           = mpc_q;
    assign out_c         = traceC_q;
    assign out_b         = traceB_q;
    assign out_ram_read  = traceRd_q;
    assign out_ram_write = traceWr_q;

endmodule

// File: tb/tb_micro_cpu.sv
// -----------------------------------------------------------------------------
// tb_micro_cpu
//   Self-checking bench for micro_cpu. Microprograms are assembled here from
//   the field layout and written through the control store port. Constants
//   are built in H by shift-left / increment chains, since the datapath has
//   no immediate field. A vector table covers ALU/shift/jam behaviour; hand
//   sequences cover memory, halt timing, run-time protection and reset.
//   All driving and sampling happens on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_micro_cpu;

    localparam int DATA_W = 32;
    localparam int MPC_W  = 8;
    localparam int UW     = 30;

    logic              clock;
    logic              reset;
    logic              start;
    logic              cs_we;
    logic [MPC_W-1:0]  cs_addr;
    logic [UW-1:0]     cs_data;
    logic              busy;
    logic              halted;
    logic [MPC_W-1:0]  mpc;
    logic [DATA_W-1:0] out_c;
    logic [DATA_W-1:0] out_b;
    logic [DATA_W-1:0] out_ram_read;
    logic [DATA_W-1:0] out_ram_write;

    int errors = 0;
    int checks = 0;
    int pcW    = 0;

    micro_cpu dut (
        .clock         (clock),
        .reset         (reset),
        .start         (start),
        .cs_we         (cs_we),
        .cs_addr       (cs_addr),
        .cs_data       (cs_data),
        .busy          (busy),
        .halted        (halted),
        .mpc           (mpc),
        .out_c         (out_c),
        .out_b         (out_b),
        .out_ram_read  (out_ram_read),
        .out_ram_write (out_ram_write)
    );

    // Free-running clock
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Hard stop in case something hangs outside a bounded wait
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "[TB] watchdog expired");
    end

    typedef struct {
        logic [31:0] hVal;
        logic [31:0] bVal;
        logic [3:0]  alu;
        logic [1:0]  shift;
        logic        jamn;
        logic        jamz;
        logic [7:0]  nxt;
        logic [31:0] expC;
        logic [7:0]  expMpc;
    } vec_t;

    vec_t vecs [14];

    function automatic logic [UW-1:0] mw(input logic [7:0] nx, input logic jn, input logic jz,
                                         input logic [1:0] sh, input logic [3:0] alu,
                                         input logic [7:0] cwr, input logic wr, input logic rd,
                                         input logic [2:0] bs, input logic hl);
        return {nx, jn, jz, sh, alu, cwr, wr, rd, bs, hl};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic csWrite(input logic [7:0] a, input logic [UW-1:0] d);
        cs_we   = 1'b1;
        cs_addr = a;
        cs_data = d;
        tick();
        cs_we   = 1'b0;
    endtask

    // Emit one sequential microword at pcW (NEXT = pcW+1)
    task automatic emitSeq(input logic [1:0] sh, input logic [3:0] alu, input logic [7:0] cwr,
                           input logic wr, input logic rd, input logic [2:0] bs, input logic hl);
        csWrite(8'(pcW), mw(8'(pcW + 1), 1'b0, 1'b0, sh, alu, cwr, wr, rd, bs, hl));
        pcW++;
    endtask

    // Build constant v in H: clear, then for each bit from the MSB down,
    // shift H left by one and increment when the bit is set
    task automatic emitLoadH(input logic [31:0] v);
        int msb;
        msb = -1;
        emitSeq(2'b00, 4'd15, 8'h01, 1'b0, 1'b0, 3'd0, 1'b0);
        for (int b = 31; b >= 0; b--) begin
            if (v[b] && msb < 0) msb = b;
        end
        for (int b = msb; b >= 0; b--) begin
            emitSeq(2'b01, 4'd0, 8'h01, 1'b0, 1'b0, 3'd0, 1'b0);
            if (v[b]) emitSeq(2'b00, 4'd4, 8'h01, 1'b0, 1'b0, 3'd0, 1'b0);
        end
    endtask

    task automatic resetDut();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic startRun();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic waitHalt(input string name, input int budget);
        int n;
        n = 0;
        while (!halted && n < budget) begin
            tick();
            n++;
        end
        checkOutput(name, 32'(halted), 32'd1);
    endtask

    // One table vector: R3 = bVal, H = bVal-then-hVal, op word writes R4 and
    // jumps to nxt; halt words at nxt and nxt|0x80 put R4 on the B/C trace
    task automatic applyStimulus(input vec_t v, input int idx);
        logic [UW-1:0] haltW;
        resetDut();
        csWrite(8'h00, mw(8'h10, 1'b0, 1'b0, 2'b00, 4'd15, 8'h00, 1'b0, 1'b0, 3'd0, 1'b0));
        pcW = 16;
        emitLoadH(v.bVal);
        emitSeq(2'b00, 4'd0, 8'h08, 1'b0, 1'b0, 3'd0, 1'b0);
        emitLoadH(v.hVal);
        csWrite(8'(pcW), mw(v.nxt, v.jamn, v.jamz, v.shift, v.alu, 8'h10, 1'b0, 1'b0, 3'd3, 1'b0));
        haltW = mw(8'h00, 1'b0, 1'b0, 2'b00, 4'd1, 8'h00, 1'b0, 1'b0, 3'd4, 1'b1);
        csWrite(v.nxt, haltW);
        csWrite(v.nxt | 8'h80, haltW);
        startRun();
        waitHalt($sformatf("vec%0d_halt", idx), 300);
        checkOutput($sformatf("vec%0d_mpc", idx), 32'(mpc), 32'(v.expMpc));
        checkOutput($sformatf("vec%0d_out_c", idx), out_c, v.expC);
        checkOutput($sformatf("vec%0d_out_b", idx), out_b, v.expC);
    endtask

    initial begin
        reset   = 1'b0;
        start   = 1'b0;
        cs_we   = 1'b0;
        cs_addr = '0;
        cs_data = '0;
        tick();

        //          hVal          bVal          alu    sh     jn    jz    nxt    expC          expMpc
        vecs[0]  = '{32'd5,        32'd7,        4'd2,  2'b00, 1'b1, 1'b1, 8'h05, 32'd12,       8'h05};
        vecs[1]  = '{32'd4,        32'd4,        4'd3,  2'b00, 1'b0, 1'b1, 8'h05, 32'd0,        8'h85};
        vecs[2]  = '{32'd4,        32'd3,        4'd3,  2'b00, 1'b0, 1'b1, 8'h05, 32'd1,        8'h05};
        vecs[3]  = '{32'd3,        32'd4,        4'd3,  2'b00, 1'b1, 1'b0, 8'h06, 32'hFFFFFFFF, 8'h86};
        vecs[4]  = '{32'd9,        32'h7F,       4'd4,  2'b01, 1'b0, 1'b0, 8'h06, 32'h100,      8'h06};
        vecs[5]  = '{32'hC,        32'hA,        4'd5,  2'b11, 1'b0, 1'b0, 8'h06, 32'h800,      8'h06};
        vecs[6]  = '{32'hC,        32'hA,        4'd6,  2'b00, 1'b1, 1'b1, 8'h07, 32'hE,        8'h07};
        vecs[7]  = '{32'd0,        32'd5,        4'd7,  2'b10, 1'b1, 1'b0, 8'h06, 32'hFFFFFFFD, 8'h86};
        vecs[8]  = '{32'h13,       32'd0,        4'd0,  2'b10, 1'b1, 1'b1, 8'h06, 32'd9,        8'h06};
        vecs[9]  = '{32'd0,        32'h81,       4'd1,  2'b01, 1'b0, 1'b0, 8'h07, 32'h102,      8'h07};
`ifdef ALU_MUL_EN
        vecs[10] = '{32'd6,        32'd7,        4'd8,  2'b00, 1'b0, 1'b1, 8'h07, 32'd42,       8'h07};
`else
        vecs[10] = '{32'd6,        32'd7,        4'd8,  2'b00, 1'b0, 1'b1, 8'h07, 32'd0,        8'h87};
`endif
        vecs[11] = '{32'd5,        32'd5,        4'd9,  2'b00, 1'b0, 1'b1, 8'h05, 32'd0,        8'h85};
        vecs[12] = '{32'h40000000, 32'd0,        4'd0,  2'b01, 1'b1, 1'b0, 8'h07, 32'h80000000, 8'h07};
        vecs[13] = '{32'h01000000, 32'd0,        4'd0,  2'b11, 1'b0, 1'b1, 8'h07, 32'd0,        8'h07};

        for (int i = 0; i < 14; i++) begin
            applyStimulus(vecs[i], i);
        end

        // Memory path: write 0xDEAD to RAM[3], clear MDR, read back while a
        // C-bus load of MDR competes with the memory read
        resetDut();
        pcW = 0;
        emitLoadH(32'd3);
        emitSeq(2'b00, 4'd0, 8'h02, 1'b0, 1'b0, 3'd0, 1'b0);
        emitLoadH(32'hDEAD);
        emitSeq(2'b00, 4'd0, 8'h04, 1'b0, 1'b0, 3'd0, 1'b0);
        emitSeq(2'b00, 4'd15, 8'h00, 1'b1, 1'b0, 3'd0, 1'b0);
        emitSeq(2'b00, 4'd15, 8'h04, 1'b0, 1'b0, 3'd0, 1'b0);
        emitSeq(2'b00, 4'd4, 8'h04, 1'b0, 1'b1, 3'd0, 1'b0);
        emitSeq(2'b00, 4'd1, 8'h00, 1'b0, 1'b0, 3'd2, 1'b1);
        startRun();
        waitHalt("mem_halt", 300);
        checkOutput("mem_out_b", out_b, 32'hDEAD);
        checkOutput("mem_out_c", out_c, 32'hDEAD);
        checkOutput("mem_out_ram_read", out_ram_read, 32'hDEAD);
        checkOutput("mem_out_ram_write", out_ram_write, 32'hDEAD);

        // Reload while halted: clear MDR, then write+read the same address
        pcW = 0;
        emitSeq(2'b00, 4'd15, 8'h04, 1'b0, 1'b0, 3'd0, 1'b0);
        emitSeq(2'b00, 4'd15, 8'h00, 1'b1, 1'b1, 3'd0, 1'b0);
        emitSeq(2'b00, 4'd1, 8'h00, 1'b0, 1'b0, 3'd2, 1'b1);
        startRun();
        waitHalt("rw_halt", 20);
        checkOutput("rw_out_b_old", out_b, 32'hDEAD);
        checkOutput("rw_out_ram_read", out_ram_read, 32'd0);
        checkOutput("rw_out_ram_write", out_ram_write, 32'hDEAD);

        // Halt timing: words 0,1 sequential, word 2 halts
        resetDut();
        csWrite(8'd0, mw(8'd1, 1'b0, 1'b0, 2'b00, 4'd15, 8'h00, 1'b0, 1'b0, 3'd0, 1'b0));
        csWrite(8'd1, mw(8'd2, 1'b0, 1'b0, 2'b00, 4'd15, 8'h00, 1'b0, 1'b0, 3'd0, 1'b0));
        csWrite(8'd2, mw(8'h33, 1'b0, 1'b0, 2'b00, 4'd15, 8'h00, 1'b0, 1'b0, 3'd0, 1'b1));
        startRun();
        checkOutput("ht_start_mpc", 32'(mpc), 32'd0);
        tick();
        tick();
        checkOutput("ht_busy_c2", 32'(busy), 32'd1);
        checkOutput("ht_halted_c2", 32'(halted), 32'd0);
        tick();
        checkOutput("ht_halted_c3", 32'(halted), 32'd1);
        checkOutput("ht_busy_c3", 32'(busy), 32'd0);
        checkOutput("ht_mpc_c3", 32'(mpc), 32'd2);
        tick();
        tick();
        checkOutput("ht_mpc_frozen", 32'(mpc), 32'd2);
        startRun();
        checkOutput("ht_restart_mpc", 32'(mpc), 32'd0);
        checkOutput("ht_restart_busy", 32'(busy), 32'd1);

        // Endless increment loop on R3: start and cs_we must be ignored in RUN
        resetDut();
        csWrite(8'd0, mw(8'd1, 1'b0, 1'b0, 2'b00, 4'd1, 8'h00, 1'b0, 1'b0, 3'd3, 1'b0));
        csWrite(8'd1, mw(8'd1, 1'b0, 1'b0, 2'b00, 4'd4, 8'h08, 1'b0, 1'b0, 3'd3, 1'b0));
        startRun();
        for (int i = 0; i < 5; i++) tick();
        checkOutput("loop_out_c", out_c, 32'd4);
        startRun();
        checkOutput("loop_start_ignored_mpc", 32'(mpc), 32'd1);
        csWrite(8'd1, mw(8'd1, 1'b0, 1'b0, 2'b00, 4'd4, 8'h08, 1'b0, 1'b0, 3'd3, 1'b1));
        tick();
        tick();
        checkOutput("loop_cswe_ignored_halted", 32'(halted), 32'd0);
        checkOutput("loop_out_c_later", out_c, 32'd8);

        // Reset in the middle of RUN, together with start
        reset = 1'b1;
        start = 1'b1;
        tick();
        reset = 1'b0;
        start = 1'b0;
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_halted", 32'(halted), 32'd0);
        checkOutput("rst_mpc", 32'(mpc), 32'd0);
        checkOutput("rst_out_c", out_c, 32'd0);
        checkOutput("rst_out_b", out_b, 32'd0);
        checkOutput("rst_out_ram_read", out_ram_read, 32'd0);
        checkOutput("rst_out_ram_write", out_ram_write, 32'd0);

        // Restart without reloading: program intact, R3 cleared
        startRun();
        tick();
        checkOutput("rst_restart_out_b", out_b, 32'd0);
        checkOutput("rst_restart_mpc", 32'(mpc), 32'd1);
        tick();
        checkOutput("rst_restart_out_c", out_c, 32'd1);
        checkOutput("rst_restart_halted", 32'(halted), 32'd0);
        resetDut();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
